// File: rtl/isqrt_shared_arbiter_if.sv
// Bundle of client, drain-control and isqrt-unit signals for isqrt_shared_arbiter.
// slave: arbiter side. master: clients / isqrt-unit side.
interface isqrt_shared_arbiter_if #(
    parameter int N_CLIENTS    = 4,
    parameter int MAX_INFLIGHT = 8
);
    localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1;

    logic [N_CLIENTS-1:0]    req_vld;
    logic [32*N_CLIENTS-1:0] req_x;
    logic [N_CLIENTS-1:0]    req_rdy;
    logic [N_CLIENTS-1:0]    rsp_vld;
    logic [15:0]             rsp_y;
    logic                    drain;
    logic                    drain_done;
    logic                    isqrt_x_vld;
    logic [31:0]             isqrt_x;
    logic                    isqrt_y_vld;
    logic [15:0]             isqrt_y;
    logic [CNT_W-1:0]        inflight;
    logic                    err_orphan;

    modport slave (
        input  req_vld, req_x, drain, isqrt_y_vld, isqrt_y,
        output req_rdy, rsp_vld, rsp_y, drain_done, isqrt_x_vld, isqrt_x,
               inflight, err_orphan
    );

    modport master (
        output req_vld, req_x, drain, isqrt_y_vld, isqrt_y,
        input  req_rdy, rsp_vld, rsp_y, drain_done, isqrt_x_vld, isqrt_x,
               inflight, err_orphan
    );
endinterface

// File: rtl/isqrt_shared_arbiter.sv
// Round-robin arbiter sharing one in-order pipelined isqrt unit between
// N_CLIENTS requesters. Accepted requests are tagged with their client index
// in an in-flight FIFO; returning roots are routed back by popping that FIFO.
// Optional feature macro: ISQRT_ARB_STATS_EN adds grant_cnt / busy_cycles.
module isqrt_shared_arbiter #(
    parameter int N_CLIENTS    = 4,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic clk,
    input  logic rst,
    isqrt_shared_arbiter_if.slave bus
`ifdef ISQRT_ARB_STATS_EN
    ,
    output logic [16*N_CLIENTS-1:0] grant_cnt,
    output logic [31:0]             busy_cycles
`endif
);
    localparam int TAG_W = $clog2(N_CLIENTS);
    localparam int PTR_W = $clog2(MAX_INFLIGHT);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DRAIN_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [TAG_W-1:0]   rr_ptr_q;
    logic [TAG_W-1:0]   gnt_idx;
    logic [TAG_W-1:0]   scan_idx;
    logic               gnt_found;
    logic [31:0]        gnt_x;
    logic [31:0]        req_x_arr [N_CLIENTS];
    logic               accept_en;
    logic               accept;
    logic               pop;
    logic               fifo_empty;
    logic               drain_done_c;
    logic [CNT_W-1:0]   cnt_q;
    logic [TAG_W-1:0]   tag_mem [MAX_INFLIGHT];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [N_CLIENTS-1:0] rsp_onehot;

    for (genvar c = 0; c < N_CLIENTS; c++) begin : g_unpack
        assign req_x_arr[c] = bus.req_x[32*c +: 32];
    end

    assign fifo_empty     = (cnt_q == '0);
    assign pop            = bus.isqrt_y_vld && !fifo_empty;
    assign accept         = accept_en && gnt_found;
    assign bus.inflight   = cnt_q;
    assign bus.drain_done = drain_done_c;

    // Round-robin search: first requester at or after the pointer, with wrap.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_x     = '0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < N_CLIENTS; k++) begin
            scan_idx = TAG_W'((32'(rr_ptr_q) + k) % N_CLIENTS);
            if (!gnt_found && bus.req_vld[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
                gnt_x     = req_x_arr[scan_idx];
            end
        end
    end

    // Ready goes only to the granted client, and only when accepting.
    always_comb begin
        bus.req_rdy = '0;
        if (accept) begin
            bus.req_rdy[gnt_idx] = 1'b1;
        end
    end

    // Run / drain state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, accept enable and drain completion pulse.
    always_comb begin
        state_d      = state_q;
        accept_en    = 1'b0;
        drain_done_c = 1'b0;
        case (state_q)
            ST_RUN: begin
                accept_en = (cnt_q < CNT_W'(MAX_INFLIGHT));
                if (bus.drain) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // An empty FIFO means no pop can be pending this cycle.
                if (cnt_q == '0) begin
                    drain_done_c = 1'b1;
                    state_d      = ST_DRAIN_WAIT;
                end
            end
            ST_DRAIN_WAIT: begin
                if (!bus.drain) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Issue accepted radicand to the isqrt unit and advance the pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.isqrt_x_vld <= 1'b0;
            bus.isqrt_x     <= '0;
            rr_ptr_q        <= '0;
        end else begin
            bus.isqrt_x_vld <= accept;
            if (accept) begin
                bus.isqrt_x <= gnt_x;
                rr_ptr_q    <= (gnt_idx == TAG_W'(N_CLIENTS - 1)) ? '0 : gnt_idx + TAG_W'(1);
            end
        end
    end

    // Tag storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem[wr_ptr_q] <= gnt_idx;
        end
    end

    // Tag FIFO pointers and outstanding-operation count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({accept, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Decode the popped tag into the client strobe.
    always_comb begin
        rsp_onehot = '0;
        rsp_onehot[tag_mem[rd_ptr_q]] = 1'b1;
    end

    // Route returning roots and flag results arriving with nothing in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rsp_vld    <= '0;
            bus.rsp_y      <= '0;
            bus.err_orphan <= 1'b0;
        end else begin
            bus.rsp_vld <= pop ? rsp_onehot : '0;
            if (pop) begin
                bus.rsp_y <= bus.isqrt_y;
            end
            if (bus.isqrt_y_vld && fifo_empty) begin
                bus.err_orphan <= 1'b1;
            end
        end
    end

`ifdef ISQRT_ARB_STATS_EN
    for (genvar c = 0; c < N_CLIENTS; c++) begin : g_grant_cnt
        // Saturating per-client accept counter.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                grant_cnt[16*c +: 16] <= '0;
            end else if (accept && gnt_idx == TAG_W'(c) && grant_cnt[16*c +: 16] != '1) begin
                grant_cnt[16*c +: 16] <= grant_cnt[16*c +: 16] + 16'd1;
            end
        end
    end

    // Saturating count of cycles with operations outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cycles <= '0;
        end else if (cnt_q != '0 && busy_cycles != '1) begin
            busy_cycles <= busy_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_isqrt_shared_arbiter.sv
// Self-checking bench for isqrt_shared_arbiter: directed scenarios plus
// randomized traffic against a queue-based reference model, with an in-order
// fixed-latency isqrt unit emulated in the bench.
module tb_isqrt_shared_arbiter;
    localparam int N   = 4;
    localparam int M   = 8;
    localparam int LAT = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    isqrt_shared_arbiter_if #(.N_CLIENTS(N), .MAX_INFLIGHT(M)) bus ();

`ifdef ISQRT_ARB_STATS_EN
    logic [16*N-1:0] grant_cnt;
    logic [31:0]     busy_cycles;
`endif

    isqrt_shared_arbiter #(.N_CLIENTS(N), .MAX_INFLIGHT(M)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef ISQRT_ARB_STATS_EN
        ,
        .grant_cnt(grant_cnt),
        .busy_cycles(busy_cycles)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // stimulus
    logic [N-1:0] d_vld;
    logic [31:0]  d_x [N];
    logic         d_drain;
    bit           hold, release_one, inject_orphan;

    // emulated isqrt unit: in-order results with due cycle
    logic [15:0]  pipe_y [$];
    int           pipe_due [$];

    // reference model
    int           m_mode;        // 0 run, 1 draining, 2 drained/waiting
    int           m_ptr;
    int           m_tag [$];
    logic [31:0]  m_x [$];
    logic [N-1:0] m_rsp_vld;
    logic [15:0]  m_rsp_y;
    logic         m_xv;
    logic [31:0]  m_xd;
    logic         m_orphan;
    int           m_gcnt [N];
    int           m_busy;
    int           grants [$];
    int           n_dd;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] isqrt_ref(logic [31:0] x);
        longint unsigned lo, hi, mid;
        lo = 0;
        hi = 65535;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= longint'(x)) lo = mid;
            else hi = mid - 1;
        end
        return 16'(lo);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_ptr = 0;
        m_tag.delete(); m_x.delete();
        m_rsp_vld = '0; m_rsp_y = '0; m_xv = 1'b0; m_xd = '0; m_orphan = 1'b0;
        for (int i = 0; i < N; i++) m_gcnt[i] = 0;
        m_busy = 0;
        pipe_y.delete(); pipe_due.delete();
    endtask

    task automatic check_regs(string pfx);
        check({pfx, "isqrt_x_vld"}, bus.isqrt_x_vld, m_xv);
        check({pfx, "isqrt_x"}, bus.isqrt_x, m_xd);
        check({pfx, "rsp_vld"}, bus.rsp_vld, m_rsp_vld);
        check({pfx, "rsp_y"}, bus.rsp_y, m_rsp_y);
        check({pfx, "inflight"}, bus.inflight, m_tag.size());
        check({pfx, "err_orphan"}, bus.err_orphan, m_orphan);
`ifdef ISQRT_ARB_STATS_EN
        for (int i = 0; i < N; i++) check({pfx, "grant_cnt"}, grant_cnt[16*i +: 16], m_gcnt[i]);
        check({pfx, "busy_cycles"}, busy_cycles, m_busy);
`endif
    endtask

    // Asynchronous reset in the middle of the low clock phase.
    task automatic do_reset();
        d_vld = '0; d_drain = 1'b0; hold = 1'b0; release_one = 1'b0; inject_orphan = 1'b0;
        bus.req_vld = '0; bus.drain = 1'b0; bus.isqrt_y_vld = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_regs("rst_");
        check("rst_req_rdy", bus.req_rdy, 0);
        check("rst_drain_done", bus.drain_done, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock cycle: starts and ends at a falling edge.
    task automatic step();
        logic        y_vld;
        logic [15:0] y;
        int          g;
        bit          en, acc, pop, exp_dd;
        logic [N-1:0] exp_rdy;
        y_vld = 1'b0;
        y = '0;
        if (pipe_y.size() > 0 && pipe_due[0] <= cyc && (!hold || release_one)) begin
            y_vld = 1'b1;
            y = pipe_y.pop_front();
            void'(pipe_due.pop_front());
            release_one = 1'b0;
        end else if (inject_orphan) begin
            y_vld = 1'b1;
            y = 16'($urandom);
            inject_orphan = 1'b0;
        end
        bus.req_vld = d_vld;
        for (int i = 0; i < N; i++) bus.req_x[32*i +: 32] = d_x[i];
        bus.drain = d_drain;
        bus.isqrt_y_vld = y_vld;
        bus.isqrt_y = y;
        #1;
        en = (m_mode == 0) && (m_tag.size() < M);
        g = -1;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (g < 0 && d_vld[c]) g = c;
        end
        acc = en && (g >= 0);
        exp_rdy = acc ? (N'(1) << g) : '0;
        exp_dd = (m_mode == 1) && (m_tag.size() == 0);
        pop = y_vld && (m_tag.size() > 0);
        check("req_rdy", bus.req_rdy, exp_rdy);
        check("drain_done", bus.drain_done, exp_dd);
        if (exp_dd) n_dd++;
        if (acc) grants.push_back(g);
        @(posedge clk);
        #1;
        cyc++;
        if (m_tag.size() != 0) m_busy++;
        if (pop) begin
            int t;
            t = m_tag.pop_front();
            m_rsp_vld = N'(1) << t;
            m_rsp_y = isqrt_ref(m_x.pop_front());
        end else begin
            m_rsp_vld = '0;
        end
        if (y_vld && !pop) m_orphan = 1'b1;
        m_xv = acc;
        if (acc) begin
            m_xd = d_x[g];
            m_tag.push_back(g);
            m_x.push_back(d_x[g]);
            m_ptr = (g + 1) % N;
            m_gcnt[g]++;
        end
        case (m_mode)
            0: if (d_drain) m_mode = 1;
            1: if (exp_dd) m_mode = 2;
            default: if (!d_drain) m_mode = 0;
        endcase
        if (bus.isqrt_x_vld === 1'b1) begin
            pipe_y.push_back(isqrt_ref(bus.isqrt_x));
            pipe_due.push_back(cyc + LAT - 1);
        end
        check_regs("");
        @(negedge clk);
    endtask

    task automatic wait_empty();
        d_vld = '0;
        hold = 1'b0;
        for (int i = 0; i < 100 && (m_tag.size() != 0 || pipe_y.size() != 0); i++) step();
        check("wait_empty_inflight", bus.inflight, 0);
    endtask

    initial begin
        d_vld = '0; d_drain = 1'b0;
        for (int i = 0; i < N; i++) d_x[i] = '0;
        bus.req_vld = '0; bus.req_x = '0; bus.drain = 1'b0;
        bus.isqrt_y_vld = 1'b0; bus.isqrt_y = '0;
        @(negedge clk);
        do_reset();

        // single request from client 2
        d_x[2] = 32'd144;
        d_vld = 4'b0100;
        step();
        check("single_isqrt_x", bus.isqrt_x, 144);
        wait_empty();

        // fairness from pointer 0
        do_reset();
        grants.delete();
        d_vld = '1;
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < N; c++) d_x[c] = $urandom;
            step();
        end
        d_vld = '0;
        check("fair_count", grants.size(), 8);
        for (int i = 0; i < grants.size(); i++) check("fair_grant", grants[i], i % N);
`ifdef ISQRT_ARB_STATS_EN
        for (int c = 0; c < N; c++) check("fair_grant_cnt", grant_cnt[16*c +: 16], 2);
`endif
        wait_empty();

        // routing with latency: clients 3,1,0 back to back
        d_x[3] = 9; d_x[1] = 16; d_x[0] = 25;
        d_vld = 4'b1000; step();
        d_vld = 4'b0010; step();
        d_vld = 4'b0001; step();
        wait_empty();

        // credit limit
        hold = 1'b1;
        for (int i = 0; i < 40 && m_tag.size() < M; i++) begin
            d_vld = N'($urandom_range(1, (1 << N) - 1));
            for (int c = 0; c < N; c++) d_x[c] = $urandom;
            step();
        end
        check("credit_full", bus.inflight, M);
        d_vld = '1;
        step(); step();
        release_one = 1'b1;
        step();
        step();
        hold = 1'b0;
        wait_empty();

        // drain with three ops in flight
        d_x[0] = 100; d_vld = 4'b0001; step();
        d_x[1] = 200; d_vld = 4'b0010; step();
        d_x[2] = 300; d_vld = 4'b0100; step();
        begin
            int g0;
            g0 = grants.size();
            n_dd = 0;
            d_drain = 1'b1;
            d_vld = '0;
            step();
            d_vld = '1;
            for (int i = 0; i < 40 && m_mode != 2; i++) step();
            step();
            check("drain_no_accept", grants.size() - g0, 0);
            check("drain_done_pulses", n_dd, 1);
            d_drain = 1'b0;
            step(); step();
            check("drain_resume", grants.size() > g0, 1);
        end
        wait_empty();

        // orphan result, then reset with ops in flight
        inject_orphan = 1'b1;
        step();
        check("orphan_flag", bus.err_orphan, 1);
        hold = 1'b1;
        d_x[0] = 49; d_x[3] = 81;
        d_vld = 4'b1001; step(); step();
        d_vld = '0;
        check("pre_reset_inflight", bus.inflight, 2);
        do_reset();

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            d_vld = N'($urandom);
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 1) == 0) begin
                    logic [31:0] r;
                    r = 32'($urandom_range(0, 65535));
                    d_x[c] = r * r;
                end else begin
                    d_x[c] = $urandom;
                end
            end
            if ($urandom_range(0, 19) == 0) hold = ~hold;
            if ($urandom_range(0, 59) == 0) d_drain = ~d_drain;
            if (m_tag.size() == 0 && $urandom_range(0, 99) == 0) inject_orphan = 1'b1;
            if ($urandom_range(0, 399) == 0) do_reset();
            else step();
        end
        d_drain = 1'b0;
        wait_empty();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
